// File: rtl/uio_bus_arbiter_if.sv
// uio_bus_arbiter_if: requester/pin-side bundle shared between the arbiter and its environment.
interface uio_bus_arbiter_if;
    logic       ena;
    logic [1:0] req;
    logic [1:0] we;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic [1:0] gnt;
    logic [1:0] ack;
    logic [7:0] rdata;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    modport master (
        output ena, req, we, wdata0, wdata1, uio_in,
        input  gnt, ack, rdata, uio_out, uio_oe
    );
    modport slave (
        input  ena, req, we, wdata0, wdata1, uio_in,
        output gnt, ack, rdata, uio_out, uio_oe
    );
endinterface

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: round-robin owner of the uio pin bank with direction-change turnaround.
// Define UIO_ARB_PARK_EN to keep the bus driven with the last write data while idle.
module uio_bus_arbiter #(
    parameter int HOLD = 2,
    parameter int TURN = 1
) (
    input logic clk,
    input logic rst_n,
    uio_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_TURN, S_XFER} state_t;
    state_t     state;
    logic       last, dir, own, lwe;
    logic [7:0] ldata;
    logic [1:0] tcnt;
    logic [3:0] hcnt;
    logic [1:0] gnt_q, ack_q;
    logic [7:0] rdata_q, out_q, oe_q;
    logic       w, nwe;
    logic [7:0] nd;
    // Contested requests go to the one that did not win last time.
    assign w   = bus.req[1] & (~bus.req[0] | ~last);
    assign nwe = bus.we[w];
    assign nd  = w ? bus.wdata1 : bus.wdata0;
    assign bus.gnt     = gnt_q;
    assign bus.ack     = ack_q;
    assign bus.rdata   = rdata_q;
    assign bus.uio_out = out_q;
    assign bus.uio_oe  = oe_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            last    <= 1'b1;
            dir     <= 1'b0;
            own     <= 1'b0;
            lwe     <= 1'b0;
            ldata   <= '0;
            tcnt    <= '0;
            hcnt    <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            out_q   <= '0;
            oe_q    <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.ena && |bus.req) begin
                    own   <= w;
                    lwe   <= nwe;
                    ldata <= nd;
                    if (TURN > 0 && nwe != dir) begin
                        state <= S_TURN;
                        tcnt  <= 2'(TURN - 1);
                        oe_q  <= '0;
                        out_q <= '0;
                    end else begin
                        state <= S_XFER;
                        hcnt  <= 4'(HOLD - 1);
                        gnt_q <= w ? 2'b10 : 2'b01;
                        ack_q <= (HOLD == 1) ? (w ? 2'b10 : 2'b01) : 2'b00;
                        oe_q  <= {8{nwe}};
                        out_q <= nwe ? nd : 8'h00;
                    end
                end
                S_TURN: if (tcnt == 0) begin
                    state <= S_XFER;
                    hcnt  <= 4'(HOLD - 1);
                    gnt_q <= own ? 2'b10 : 2'b01;
                    ack_q <= (HOLD == 1) ? (own ? 2'b10 : 2'b01) : 2'b00;
                    oe_q  <= {8{lwe}};
                    out_q <= lwe ? ldata : 8'h00;
                end else begin
                    tcnt <= tcnt - 2'd1;
                end
                S_XFER: if (hcnt == 0) begin
                    state <= S_IDLE;
                    gnt_q <= '0;
                    ack_q <= '0;
                    last  <= own;
                    dir   <= lwe;
                    if (!lwe) rdata_q <= bus.uio_in;
`ifdef UIO_ARB_PARK_EN
                    oe_q  <= oe_q;
                    out_q <= out_q;
`else
                    oe_q  <= '0;
                    out_q <= '0;
`endif
                end else begin
                    hcnt  <= hcnt - 4'd1;
                    ack_q <= (hcnt == 4'd1) ? gnt_q : 2'b00;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uio_bus_arbiter.sv
// tb_uio_bus_arbiter: cycle-by-cycle vector table plus an async-reset sequence, HOLD=2 TURN=1.
module tb_uio_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ncmp = 0;
    int   nerr = 0;
    uio_bus_arbiter_if bus();
    uio_bus_arbiter #(.HOLD(2), .TURN(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic       ena;
        logic [1:0] req, we;
        logic [7:0] wd0, wd1, uin;
        logic [1:0] gnt, ack;
        logic [7:0] oe, out, rdata;
    } vec_t;
    vec_t v[30];
    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        ncmp++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask
    task automatic drive(input logic e, input logic [1:0] r, input logic [1:0] d,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] u);
        bus.ena = e; bus.req = r; bus.we = d; bus.wdata0 = a; bus.wdata1 = b; bus.uio_in = u;
    endtask
    initial begin
        // ena req we wd0 wd1 uin | gnt ack oe out rdata
        v[0]  = '{1, 2'b01, 2'b01, 8'hA5, 8'h5A, 8'h3C, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00};
        v[1]  = '{1, 2'b01, 2'b01, 8'hA5, 8'h5A, 8'h3C, 2'b01, 2'b00, 8'hFF, 8'hA5, 8'h00};
        v[2]  = '{1, 2'b00, 2'b01, 8'h00, 8'h5A, 8'h3C, 2'b01, 2'b01, 8'hFF, 8'hA5, 8'h00};
        v[3]  = '{1, 2'b10, 2'b00, 8'h00, 8'h5A, 8'h3C, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00};
        v[4]  = '{1, 2'b10, 2'b00, 8'h00, 8'h5A, 8'h3C, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00};
        v[5]  = '{1, 2'b10, 2'b00, 8'h00, 8'h5A, 8'h3C, 2'b10, 2'b00, 8'h00, 8'h00, 8'h00};
        v[6]  = '{1, 2'b10, 2'b00, 8'h00, 8'h5A, 8'h3C, 2'b10, 2'b10, 8'h00, 8'h00, 8'h00};
        v[7]  = '{1, 2'b11, 2'b00, 8'h00, 8'h5A, 8'h3C, 2'b00, 2'b00, 8'h00, 8'h00, 8'h3C};
        v[8]  = '{1, 2'b11, 2'b00, 8'h00, 8'h5A, 8'h3C, 2'b01, 2'b00, 8'h00, 8'h00, 8'h3C};
        v[9]  = '{1, 2'b11, 2'b00, 8'h00, 8'h5A, 8'h3C, 2'b01, 2'b01, 8'h00, 8'h00, 8'h3C};
        v[10] = '{1, 2'b11, 2'b00, 8'h00, 8'h5A, 8'h77, 2'b00, 2'b00, 8'h00, 8'h00, 8'h77};
        v[11] = '{1, 2'b11, 2'b00, 8'h00, 8'h5A, 8'h77, 2'b10, 2'b00, 8'h00, 8'h00, 8'h77};
        v[12] = '{1, 2'b11, 2'b00, 8'h00, 8'h5A, 8'h77, 2'b10, 2'b10, 8'h00, 8'h00, 8'h77};
        v[13] = '{1, 2'b11, 2'b00, 8'h00, 8'h5A, 8'hC3, 2'b00, 2'b00, 8'h00, 8'h00, 8'hC3};
        v[14] = '{0, 2'b11, 2'b00, 8'h00, 8'h5A, 8'hC3, 2'b00, 2'b00, 8'h00, 8'h00, 8'hC3};
        v[15] = '{0, 2'b11, 2'b00, 8'h00, 8'h5A, 8'hC3, 2'b00, 2'b00, 8'h00, 8'h00, 8'hC3};
        v[16] = '{1, 2'b11, 2'b00, 8'h00, 8'h5A, 8'hC3, 2'b01, 2'b00, 8'h00, 8'h00, 8'hC3};
        v[17] = '{1, 2'b11, 2'b00, 8'h00, 8'h5A, 8'hC3, 2'b01, 2'b01, 8'h00, 8'h00, 8'hC3};
        v[18] = '{1, 2'b11, 2'b11, 8'h11, 8'h22, 8'hC3, 2'b00, 2'b00, 8'h00, 8'h00, 8'hC3};
        v[19] = '{1, 2'b11, 2'b11, 8'h11, 8'h22, 8'hC3, 2'b00, 2'b00, 8'h00, 8'h00, 8'hC3};
        v[20] = '{1, 2'b11, 2'b11, 8'h11, 8'h22, 8'hC3, 2'b10, 2'b00, 8'hFF, 8'h22, 8'hC3};
        v[21] = '{1, 2'b11, 2'b11, 8'h11, 8'h22, 8'hC3, 2'b10, 2'b10, 8'hFF, 8'h22, 8'hC3};
        v[22] = '{1, 2'b11, 2'b11, 8'h11, 8'h22, 8'hC3, 2'b00, 2'b00, 8'h00, 8'h00, 8'hC3};
        v[23] = '{1, 2'b11, 2'b11, 8'h11, 8'h22, 8'hC3, 2'b01, 2'b00, 8'hFF, 8'h11, 8'hC3};
        v[24] = '{1, 2'b11, 2'b11, 8'h11, 8'h22, 8'hC3, 2'b01, 2'b01, 8'hFF, 8'h11, 8'hC3};
        v[25] = '{1, 2'b00, 2'b00, 8'h11, 8'h22, 8'hC3, 2'b00, 2'b00, 8'h00, 8'h00, 8'hC3};
        v[26] = '{1, 2'b10, 2'b00, 8'h11, 8'h22, 8'h5A, 2'b00, 2'b00, 8'h00, 8'h00, 8'hC3};
        v[27] = '{1, 2'b10, 2'b00, 8'h11, 8'h22, 8'h5A, 2'b10, 2'b00, 8'h00, 8'h00, 8'hC3};
        v[28] = '{1, 2'b10, 2'b00, 8'h11, 8'h22, 8'h5A, 2'b10, 2'b10, 8'h00, 8'h00, 8'hC3};
        v[29] = '{1, 2'b00, 2'b00, 8'h11, 8'h22, 8'h5A, 2'b00, 2'b00, 8'h00, 8'h00, 8'h5A};
        drive(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("reset gnt", 8'(bus.gnt), 8'h00);
        chk("reset ack", 8'(bus.ack), 8'h00);
        chk("reset oe", bus.uio_oe, 8'h00);
        chk("reset out", bus.uio_out, 8'h00);
        chk("reset rdata", bus.rdata, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            drive(v[i].ena, v[i].req, v[i].we, v[i].wd0, v[i].wd1, v[i].uin);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d gnt", i), 8'(bus.gnt), 8'(v[i].gnt));
            chk($sformatf("row%0d ack", i), 8'(bus.ack), 8'(v[i].ack));
            chk($sformatf("row%0d oe", i), bus.uio_oe, v[i].oe);
            chk($sformatf("row%0d out", i), bus.uio_out, v[i].out);
            chk($sformatf("row%0d rdata", i), bus.rdata, v[i].rdata);
        end
        // Asynchronous reset in the middle of a write XFER, then fresh arbitration.
        drive(1'b1, 2'b01, 2'b01, 8'hA5, 8'h5A, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("pre-rst gnt", 8'(bus.gnt), 8'h01);
        chk("pre-rst oe", bus.uio_oe, 8'hFF);
        #3 rst_n = 1'b0;
        #1;
        chk("async rst gnt", 8'(bus.gnt), 8'h00);
        chk("async rst ack", 8'(bus.ack), 8'h00);
        chk("async rst oe", bus.uio_oe, 8'h00);
        chk("async rst out", bus.uio_out, 8'h00);
        chk("async rst rdata", bus.rdata, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 2'b11, 2'b00, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        chk("post-rst gnt", 8'(bus.gnt), 8'h01);
        chk("post-rst oe", bus.uio_oe, 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
